// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// funct3 access codes, load/store opcodes and the responder FSM state type.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    // Unsigned variants exist only for loads; everything else is rejected.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic is_store);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated write data for
// stores, lane extraction plus sign/zero extension for loads, misalign detect.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // Offsets are forced to natural alignment; trapping is decided by the caller.
    always_comb begin
        off      = addr_lo;
        byte_en  = '0;
        wword    = wdata;
        misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                off     = addr_lo;
                byte_en = 4'b0001 << off;
                wword   = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                misalign = addr_lo[0];
                off      = {addr_lo[1], 1'b0};
                byte_en  = 4'b0011 << off;
                wword    = {2{wdata[15:0]}};
            end
            F3_W: begin
                misalign = |addr_lo;
                off      = 2'b00;
                byte_en  = 4'b1111;
                wword    = wdata;
            end
            default: begin
                off     = 2'b00;
                byte_en = '0;
            end
        endcase
    end

    assign shifted = rword >> {off, 3'b000};

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'h000000, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'h0000, shifted[15:0]};
            F3_W:    rdata = rword;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store, fixed LATENCY,
// pipeline stall generation. Define DMEM_MISALIGN_TRAP_EN to report misaligned
// accesses through rsp_err instead of silently aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [2:0]    req_funct3,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          mem_stall
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_e state, state_nxt;
    logic [3:0]  cnt;

    logic          r_write;
    logic [2:0]    r_f3;
    logic [IW+1:0] r_addr;
    logic [31:0]   r_wdata;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          go_resp;
    logic          in_wait;
    logic          acc_write;
    logic [2:0]    acc_f3;
    logic [IW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [31:0]   acc_rword;
    logic          acc_bad;
    logic          mem_we;

    logic [3:0]  al_be;
    logic [31:0] al_wword;
    logic [31:0] al_rdata;
    logic        al_misalign;

    logic [31:0] rdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[AW-1:IW+2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_stall = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_stall = req_valid;
                if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
                else           state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = req_valid & req_ready;
    assign in_wait = (state == WAIT);
    assign go_resp = (in_wait && cnt == '0) || (accept && LATENCY == 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 cnt <= '0;
        else if (accept)              cnt <= CNT_INIT;
        else if (in_wait && cnt != '0) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (accept) begin
            r_write <= req_write;
            r_f3    <= req_funct3;
            r_addr  <= req_addr[IW+1:0];
            r_wdata <= req_wdata;
        end
    end

    // With LATENCY=1 the access completes on the accepting edge, so the live
    // request fields feed the datapath; otherwise the registered copy does.
    assign acc_write = in_wait ? r_write   : req_write;
    assign acc_f3    = in_wait ? r_f3      : req_funct3;
    assign acc_addr  = in_wait ? r_addr    : req_addr[IW+1:0];
    assign acc_wdata = in_wait ? r_wdata   : req_wdata;
    assign acc_rword = mem[acc_addr[IW+1:2]];

    dmem_lane_align u_align (
        .funct3   (acc_f3),
        .addr_lo  (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .rword    (acc_rword),
        .byte_en  (al_be),
        .wword    (al_wword),
        .rdata    (al_rdata),
        .misalign (al_misalign)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    assign acc_bad = ~f3_legal(acc_f3, acc_write) | al_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     err_q <= 1'b0;
        else if (go_resp) err_q <= acc_bad;
    end

    assign rsp_err = rsp_valid & err_q;
`else
    logic unused_misalign;

    assign unused_misalign = al_misalign;
    assign acc_bad         = ~f3_legal(acc_f3, acc_write);
    assign rsp_err         = 1'b0;
`endif

    // Gating with reset_n keeps a store that meets an asserted reset from landing.
    assign mem_we = go_resp & acc_write & ~acc_bad & reset_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (al_be[b]) mem[acc_addr[IW+1:2]][8*b +: 8] <= al_wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     rdata_q <= '0;
        else if (go_resp) rdata_q <= (acc_write | acc_bad) ? 32'h0 : al_rdata;
    end

    assign rsp_rdata = rdata_q;

endmodule
